// File: rtl/voq_wr_ctrl_if.sv
// ---------------------------------------------------------------------------
// voq_wr_ctrl_if
// Groups the cell-input handshake and the VOQ read/status signals of one
// switch input port.
//   master : the port / switch controller side (drives cells and read requests)
//   slave  : the VOQ bank (voq_wr_ctrl)
// Signals:
//   in_valid/in_ready/in_sop/in_dest/in_data : cell word stream into the bank
//   full_out[d]                               : VOQ d holds at least one cell
//   rd_en/rd_sel                              : read request for one cell
//   rd_valid/rd_data/rd_busy                  : cell word stream out of the bank
//   err_out                                   : one-cycle protocol error pulse
// ---------------------------------------------------------------------------
`ifndef PORT_NUB_TOTAL
`define PORT_NUB_TOTAL 4
`endif

interface voq_wr_ctrl_if #(
    parameter int PORT_NUB   = `PORT_NUB_TOTAL,
    parameter int WIDTH_SEL  = (PORT_NUB > 1) ? $clog2(PORT_NUB) : 1,
    parameter int DATA_WIDTH = 32
);
    logic                  in_valid;
    logic                  in_ready;
    logic                  in_sop;
    logic [WIDTH_SEL-1:0]  in_dest;
    logic [DATA_WIDTH-1:0] in_data;
    logic [PORT_NUB-1:0]   full_out;
    logic                  rd_en;
    logic [WIDTH_SEL-1:0]  rd_sel;
    logic                  rd_valid;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  rd_busy;
    logic                  err_out;

    modport master (
        output in_valid, in_sop, in_dest, in_data, rd_en, rd_sel,
        input  in_ready, full_out, rd_valid, rd_data, rd_busy, err_out
    );

    modport slave (
        input  in_valid, in_sop, in_dest, in_data, rd_en, rd_sel,
        output in_ready, full_out, rd_valid, rd_data, rd_busy, err_out
    );
endinterface

// File: rtl/voq_wr_ctrl.sv
// ---------------------------------------------------------------------------
// voq_wr_ctrl
// Input-side virtual output queue bank for one switch input port. Fixed-length
// cells arriving on the input stream are steered into the VOQ of their
// destination; a controller later drains one cell at a time via rd_en/rd_sel.
// Ports:
//   clk  : clock
//   rst  : synchronous active-high reset
//   bus  : voq_wr_ctrl_if.slave (input stream, read request/stream, status)
// Storage is PORT_NUB x VOQ_DEPTH x CELL_LEN words. Each VOQ keeps a write
// cell pointer, a read cell pointer and a committed-cell count. A cell being
// read stays counted until its last word leaves, so its slot cannot be
// overwritten while it is streaming out.
// ---------------------------------------------------------------------------
`ifndef PORT_NUB_TOTAL
`define PORT_NUB_TOTAL 4
`endif

module voq_wr_ctrl #(
    parameter int PORT_NUB   = `PORT_NUB_TOTAL,
    parameter int WIDTH_SEL  = (PORT_NUB > 1) ? $clog2(PORT_NUB) : 1,
    parameter int DATA_WIDTH = 32,
    parameter int CELL_LEN   = 4,
    parameter int VOQ_DEPTH  = 2
) (
    input  logic          clk,
    input  logic          rst,
    voq_wr_ctrl_if.slave  bus
);

    localparam int IW = $clog2(CELL_LEN);
    localparam int PW = (VOQ_DEPTH > 1) ? $clog2(VOQ_DEPTH) : 1;
    localparam int CW = $clog2(VOQ_DEPTH + 1);

    localparam logic [CW-1:0] DEPTH_C  = CW'(VOQ_DEPTH);
    localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [IW-1:0] IDX_ZERO = {IW{1'b0}};
    localparam logic [IW-1:0] IDX_ONE  = IW'(1);
    localparam logic [IW-1:0] IDX_LAST = IW'(CELL_LEN - 1);
    localparam logic [PW-1:0] PTR_ZERO = {PW{1'b0}};
    localparam logic [PW-1:0] PTR_ONE  = PW'(1);
    localparam logic [PW-1:0] PTR_LAST = PW'(VOQ_DEPTH - 1);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RECV = 1'b1
    } wr_state_e;

    // Cell slot pointer with wrap at the last slot of a VOQ.
    function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
        ptr_next = (p == PTR_LAST) ? PTR_ZERO : (p + PTR_ONE);
    endfunction

    // Storage
    logic [DATA_WIDTH-1:0] mem_q [PORT_NUB][VOQ_DEPTH][CELL_LEN];

    // Per-VOQ bookkeeping
    logic [PW-1:0] wr_ptr_q [PORT_NUB];
    logic [PW-1:0] rd_ptr_q [PORT_NUB];
    logic [CW-1:0] cnt_q    [PORT_NUB];

    // Write FSM state
    wr_state_e            state_q, state_d;
    logic [WIDTH_SEL-1:0] dest_q, dest_d;
    logic [IW-1:0]        widx_q, widx_d;

    // Write-side decode
    logic                 in_ready_s;
    logic                 wr_en_s;
    logic [WIDTH_SEL-1:0] wr_dest_s;
    logic [IW-1:0]        wr_idx_s;
    logic                 commit_s;
    logic                 wr_err_s;

    // Read-side state and decode
    logic                  rd_busy_q;
    logic [WIDTH_SEL-1:0]  rd_sel_q;
    logic [IW-1:0]         ridx_q;
    logic                  rd_valid_q;
    logic [DATA_WIDTH-1:0] rd_data_q;
    logic                  rd_ok_s;
    logic                  rd_err_s;
    logic                  rd_last_s;

    logic                  err_q;
    logic [PORT_NUB-1:0]   inc_s;
    logic [PORT_NUB-1:0]   dec_s;
    logic [PORT_NUB-1:0]   full_s;

    // Write FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            dest_q  <= {WIDTH_SEL{1'b0}};
            widx_q  <= IDX_ZERO;
        end else begin
            state_q <= state_d;
            dest_q  <= dest_d;
            widx_q  <= widx_d;
        end
    end

    // Write FSM next state, input handshake and storage write strobe.
    always_comb begin
        state_d    = state_q;
        dest_d     = dest_q;
        widx_d     = widx_q;
        in_ready_s = 1'b0;
        wr_en_s    = 1'b0;
        wr_dest_s  = dest_q;
        wr_idx_s   = widx_q;
        commit_s   = 1'b0;
        wr_err_s   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                // Stray non-sop words are always swallowed; a sop waits for room.
                if (bus.in_sop) begin
                    in_ready_s = (cnt_q[bus.in_dest] < DEPTH_C);
                end else begin
                    in_ready_s = 1'b1;
                end
                if (bus.in_valid && in_ready_s) begin
                    if (bus.in_sop) begin
                        wr_en_s   = 1'b1;
                        wr_dest_s = bus.in_dest;
                        wr_idx_s  = IDX_ZERO;
                        dest_d    = bus.in_dest;
                        widx_d    = IDX_ONE;
                        state_d   = ST_RECV;
                    end else begin
                        wr_err_s = 1'b1;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RECV: begin
                // A sop inside a cell aborts it; the sop is left for IDLE.
                in_ready_s = !bus.in_sop;
                if (bus.in_valid && bus.in_sop) begin
                    wr_err_s = 1'b1;
                    widx_d   = IDX_ZERO;
                    state_d  = ST_IDLE;
                end else if (bus.in_valid) begin
                    wr_en_s = 1'b1;
                    if (widx_q == IDX_LAST) begin
                        commit_s = 1'b1;
                        widx_d   = IDX_ZERO;
                        state_d  = ST_IDLE;
                    end else begin
                        widx_d = widx_q + IDX_ONE;
                    end
                end else begin
                    state_d = ST_RECV;
                end
            end
            default: begin
                state_d = ST_IDLE;
                widx_d  = IDX_ZERO;
            end
        endcase
    end

    // Cell storage write port; contents need no reset.
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            mem_q[wr_dest_s][wr_ptr_q[wr_dest_s]][wr_idx_s] <= bus.in_data;
        end
    end

    // Read request decode: a busy read port ignores requests silently,
    // but any request to an empty VOQ is flagged.
    always_comb begin
        rd_ok_s   = bus.rd_en && !rd_busy_q && (cnt_q[bus.rd_sel] != CNT_ZERO);
        rd_err_s  = bus.rd_en && (cnt_q[bus.rd_sel] == CNT_ZERO);
        rd_last_s = rd_busy_q && (ridx_q == IDX_LAST);
    end

    // Read streamer: word 0 is launched on acceptance, the rest follow back-to-back.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_busy_q  <= 1'b0;
            rd_sel_q   <= {WIDTH_SEL{1'b0}};
            ridx_q     <= IDX_ZERO;
            rd_valid_q <= 1'b0;
            rd_data_q  <= {DATA_WIDTH{1'b0}};
        end else if (rd_ok_s) begin
            rd_busy_q  <= 1'b1;
            rd_sel_q   <= bus.rd_sel;
            ridx_q     <= IDX_ONE;
            rd_valid_q <= 1'b1;
            rd_data_q  <= mem_q[bus.rd_sel][rd_ptr_q[bus.rd_sel]][IDX_ZERO];
        end else if (rd_busy_q) begin
            rd_valid_q <= 1'b1;
            rd_data_q  <= mem_q[rd_sel_q][rd_ptr_q[rd_sel_q]][ridx_q];
            if (rd_last_s) begin
                rd_busy_q <= 1'b0;
                ridx_q    <= IDX_ZERO;
            end else begin
                ridx_q <= ridx_q + IDX_ONE;
            end
        end else begin
            rd_valid_q <= 1'b0;
        end
    end

    // Per-VOQ commit / release strobes.
    always_comb begin
        inc_s = {PORT_NUB{1'b0}};
        dec_s = {PORT_NUB{1'b0}};
        for (int d = 0; d < PORT_NUB; d++) begin
            inc_s[d] = commit_s && (dest_q == WIDTH_SEL'(d));
            dec_s[d] = rd_last_s && (rd_sel_q == WIDTH_SEL'(d));
        end
    end

    // Counts and cell pointers; a commit and a release on the same VOQ cancel.
    always_ff @(posedge clk) begin
        for (int d = 0; d < PORT_NUB; d++) begin
            if (rst) begin
                cnt_q[d]    <= CNT_ZERO;
                wr_ptr_q[d] <= PTR_ZERO;
                rd_ptr_q[d] <= PTR_ZERO;
            end else begin
                if (inc_s[d] && !dec_s[d]) begin
                    cnt_q[d] <= cnt_q[d] + CNT_ONE;
                end else if (dec_s[d] && !inc_s[d]) begin
                    cnt_q[d] <= cnt_q[d] - CNT_ONE;
                end else begin
                    cnt_q[d] <= cnt_q[d];
                end
                if (inc_s[d]) begin
                    wr_ptr_q[d] <= ptr_next(wr_ptr_q[d]);
                end else begin
                    wr_ptr_q[d] <= wr_ptr_q[d];
                end
                if (dec_s[d]) begin
                    rd_ptr_q[d] <= ptr_next(rd_ptr_q[d]);
                end else begin
                    rd_ptr_q[d] <= rd_ptr_q[d];
                end
            end
        end
    end

    // Registered error pulse, merged from write and read protocol errors.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
        end else begin
            err_q <= wr_err_s || rd_err_s;
        end
    end

    // Occupancy flags straight from the committed counts.
    always_comb begin
        full_s = {PORT_NUB{1'b0}};
        for (int d = 0; d < PORT_NUB; d++) begin
            full_s[d] = (cnt_q[d] != CNT_ZERO);
        end
    end

    assign bus.in_ready = in_ready_s && !rst;
    assign bus.full_out = full_s;
    assign bus.rd_valid = rd_valid_q;
    assign bus.rd_data  = rd_data_q;
    assign bus.rd_busy  = rd_busy_q;
    assign bus.err_out  = err_q;

endmodule

// File: tb/tb_voq_wr_ctrl.sv
// ---------------------------------------------------------------------------
// tb_voq_wr_ctrl
// Directed scenarios followed by randomized traffic. A queue-based model of
// the VOQ bank predicts every output; one compare process checks the DUT at
// each falling edge, and literal expectations pin key scenario points.
// ---------------------------------------------------------------------------
module tb_voq_wr_ctrl;

    localparam int NP    = 4;
    localparam int CL    = 4;
    localparam int DEPTH = 2;

    logic clk;
    logic rst;

    voq_wr_ctrl_if #(.PORT_NUB(NP), .WIDTH_SEL(2), .DATA_WIDTH(32)) bus ();

    voq_wr_ctrl #(
        .PORT_NUB(NP), .WIDTH_SEL(2), .DATA_WIDTH(32), .CELL_LEN(CL), .VOQ_DEPTH(DEPTH)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    // ---------------- behavioural model ----------------
    logic [31:0] voqw [NP][$];   // committed cells, CL words each, oldest first
    logic [31:0] part [$];       // partial cell being received
    bit          in_cell = 1'b0;
    int          mdest = 0;
    logic [31:0] pend [$];       // words still to be streamed after the current one
    int          rvoq = 0;
    bit          e_valid = 1'b0;
    bit          e_err = 1'b0;
    logic [31:0] e_data = 32'd0;

    function automatic bit exp_ready();
        if (rst) return 1'b0;
        if (in_cell) return !bus.in_sop;
        if (bus.in_sop) return (voqw[bus.in_dest].size() < DEPTH * CL);
        return 1'b1;
    endfunction

    function automatic logic [3:0] exp_full();
        logic [3:0] f;
        for (int d = 0; d < NP; d++) f[d] = (voqw[d].size() > 0);
        return f;
    endfunction

    function automatic void model_step();
        bit rdy, err_w, err_r, fin, commit;
        int rs;
        if (rst) begin
            for (int d = 0; d < NP; d++) voqw[d].delete();
            part.delete();
            pend.delete();
            in_cell = 1'b0;
            e_valid = 1'b0;
            e_err   = 1'b0;
            e_data  = 32'd0;
            return;
        end
        rdy = exp_ready();
        err_w = 1'b0; err_r = 1'b0; fin = 1'b0; commit = 1'b0;
        rs = int'(bus.rd_sel);
        if (bus.rd_en && voqw[rs].size() == 0) err_r = 1'b1;
        if (bus.rd_en && pend.size() == 0 && voqw[rs].size() > 0) begin
            e_valid = 1'b1;
            e_data  = voqw[rs][0];
            for (int i = 1; i < CL; i++) pend.push_back(voqw[rs][i]);
            rvoq = rs;
        end else if (pend.size() > 0) begin
            e_valid = 1'b1;
            e_data  = pend.pop_front();
            if (pend.size() == 0) fin = 1'b1;
        end else begin
            e_valid = 1'b0;
        end
        if (bus.in_valid) begin
            if (in_cell) begin
                if (bus.in_sop) begin
                    err_w = 1'b1;
                    in_cell = 1'b0;
                    part.delete();
                end else begin
                    part.push_back(bus.in_data);
                    if (part.size() == CL) commit = 1'b1;
                end
            end else if (rdy) begin
                if (bus.in_sop) begin
                    in_cell = 1'b1;
                    mdest = int'(bus.in_dest);
                    part.delete();
                    part.push_back(bus.in_data);
                end else begin
                    err_w = 1'b1;
                end
            end
        end
        if (commit) begin
            for (int i = 0; i < CL; i++) voqw[mdest].push_back(part[i]);
            part.delete();
            in_cell = 1'b0;
        end
        if (fin) begin
            for (int i = 0; i < CL; i++) void'(voqw[rvoq].pop_front());
        end
        e_err = err_w | err_r;
    endfunction

    // ---------------- checking ----------------
    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
        end
    endtask

    // Compare process: every cycle against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            check("in_ready", 32'(bus.in_ready), 32'(exp_ready()));
            check("full_out", 32'(bus.full_out), 32'(exp_full()));
            check("rd_valid", 32'(bus.rd_valid), 32'(e_valid));
            check("rd_busy",  32'(bus.rd_busy),  32'(pend.size() != 0));
            check("err_out",  32'(bus.err_out),  32'(e_err));
            if (e_valid) check("rd_data", bus.rd_data, e_data);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic cyc();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic send_word(input bit sop, input int dest, input logic [31:0] data);
        bit acc;
        bus.in_valid = 1'b1;
        bus.in_sop   = sop;
        bus.in_dest  = dest[1:0];
        bus.in_data  = data;
        acc = 1'b0;
        for (int n = 0; n < 64 && !acc; n++) begin
            #2;
            acc = bus.in_ready;
            cyc();
        end
        check("hs_timeout", 32'(acc), 32'd1);
    endtask

    task automatic send_cell(input int dest, input logic [31:0] base);
        for (int w = 0; w < CL; w++) send_word(w == 0, dest, base + 32'(w));
        bus.in_valid = 1'b0;
        bus.in_sop   = 1'b0;
    endtask

    task automatic read_cell(input int sel, input logic [31:0] base);
        bus.rd_en  = 1'b1;
        bus.rd_sel = sel[1:0];
        cyc();
        bus.rd_en = 1'b0;
        for (int w = 0; w < CL; w++) begin
            check("pin_rd_valid", 32'(bus.rd_valid), 32'd1);
            check("pin_rd_data", bus.rd_data, base + 32'(w));
            if (w < CL - 1) cyc();
        end
    endtask

    initial begin
        rst = 1'b1;
        bus.in_valid = 1'b0; bus.in_sop = 1'b0; bus.in_dest = 2'd0; bus.in_data = 32'd0;
        bus.rd_en = 1'b0; bus.rd_sel = 2'd0;
        cyc();
        chk_en = 1'b1;
        check("pin_rst_full",  32'(bus.full_out), 32'd0);
        check("pin_rst_valid", 32'(bus.rd_valid), 32'd0);
        check("pin_rst_data",  bus.rd_data,       32'd0);
        check("pin_rst_busy",  32'(bus.rd_busy),  32'd0);
        check("pin_rst_err",   32'(bus.err_out),  32'd0);
        check("pin_rst_ready", 32'(bus.in_ready), 32'd0);
        cyc();
        rst = 1'b0;
        #1;
        check("pin_ready_after_rst", 32'(bus.in_ready), 32'd1);

        // Cell to dest 2, then read it back.
        send_cell(2, 32'hA000_0000);
        check("pin_full_d2", 32'(bus.full_out), 32'h4);
        read_cell(2, 32'hA000_0000);
        check("pin_full_after_rd", 32'(bus.full_out), 32'h0);
        cyc();
        check("pin_rd_done", 32'(bus.rd_valid), 32'd0);

        // Three cells to dest 1: third is back-pressured until a read frees a slot.
        send_cell(1, 32'hB000_0000);
        send_cell(1, 32'hC000_0000);
        bus.in_valid = 1'b1; bus.in_sop = 1'b1; bus.in_dest = 2'd1; bus.in_data = 32'hD000_0000;
        #2;
        check("pin_held_ready", 32'(bus.in_ready), 32'd0);
        bus.rd_en = 1'b1; bus.rd_sel = 2'd1;
        cyc();
        bus.rd_en = 1'b0;
        check("pin_fifo_b0", bus.rd_data, 32'hB000_0000);
        check("pin_held_ready2", 32'(bus.in_ready), 32'd0);
        cyc(); cyc(); cyc();
        check("pin_b3", bus.rd_data, 32'hB000_0003);
        check("pin_ready_freed", 32'(bus.in_ready), 32'd1);
        cyc();
        for (int w = 1; w < CL; w++) send_word(1'b0, 1, 32'hD000_0000 + 32'(w));
        bus.in_valid = 1'b0; bus.in_sop = 1'b0;
        read_cell(1, 32'hC000_0000);
        read_cell(1, 32'hD000_0000);
        cyc();

        // sop inside a dest-0 cell aborts it; the next cell to dest 3 is clean.
        send_word(1'b1, 0, 32'hE000_0000);
        send_word(1'b0, 0, 32'hE000_0001);
        bus.in_valid = 1'b1; bus.in_sop = 1'b1; bus.in_dest = 2'd3; bus.in_data = 32'hF000_0000;
        #2;
        check("pin_abort_ready", 32'(bus.in_ready), 32'd0);
        cyc();
        check("pin_abort_err", 32'(bus.err_out), 32'd1);
        #1;
        check("pin_resop_ready", 32'(bus.in_ready), 32'd1);
        cyc();
        check("pin_err_once", 32'(bus.err_out), 32'd0);
        for (int w = 1; w < CL; w++) send_word(1'b0, 3, 32'hF000_0000 + 32'(w));
        bus.in_valid = 1'b0; bus.in_sop = 1'b0;
        check("pin_full_d3", 32'(bus.full_out), 32'h8);
        read_cell(3, 32'hF000_0000);
        cyc();

        // Read of an empty VOQ, and a request while busy.
        bus.rd_en = 1'b1; bus.rd_sel = 2'd3;
        cyc();
        bus.rd_en = 1'b0;
        check("pin_empty_err", 32'(bus.err_out), 32'd1);
        check("pin_empty_valid", 32'(bus.rd_valid), 32'd0);
        send_cell(0, 32'h5000_0000);
        bus.rd_en = 1'b1; bus.rd_sel = 2'd0;
        cyc();
        cyc();
        bus.rd_en = 1'b0;
        check("pin_busy_noerr", 32'(bus.err_out), 32'd0);
        check("pin_busy", 32'(bus.rd_busy), 32'd1);
        cyc(); cyc(); cyc();
        check("pin_busy_ignored", 32'(bus.rd_valid), 32'd0);

        // Commit and read-finish on the same VOQ at the same edge.
        send_cell(1, 32'h6000_0000);
        bus.rd_en = 1'b1; bus.rd_sel = 2'd1;
        bus.in_valid = 1'b1; bus.in_sop = 1'b1; bus.in_dest = 2'd1; bus.in_data = 32'h7000_0000;
        cyc();
        bus.rd_en = 1'b0; bus.in_sop = 1'b0;
        for (int w = 1; w < CL; w++) begin
            bus.in_data = 32'h7000_0000 + 32'(w);
            cyc();
        end
        bus.in_valid = 1'b0;
        check("pin_same_edge_full", 32'(bus.full_out[1]), 32'd1);
        check("pin_same_edge_data", bus.rd_data, 32'h6000_0003);
        cyc();
        check("pin_same_edge_full2", 32'(bus.full_out[1]), 32'd1);
        read_cell(1, 32'h7000_0000);
        cyc();

        // Reset mid-read and mid-cell.
        send_cell(2, 32'h8000_0000);
        bus.rd_en = 1'b1; bus.rd_sel = 2'd2;
        cyc();
        bus.rd_en = 1'b0;
        bus.in_valid = 1'b1; bus.in_sop = 1'b1; bus.in_dest = 2'd0; bus.in_data = 32'h9000_0000;
        cyc();
        bus.in_sop = 1'b0; bus.in_data = 32'h9000_0001;
        cyc();
        rst = 1'b1; bus.in_valid = 1'b0;
        cyc();
        check("pin_mid_rst_valid", 32'(bus.rd_valid), 32'd0);
        check("pin_mid_rst_busy",  32'(bus.rd_busy),  32'd0);
        check("pin_mid_rst_full",  32'(bus.full_out), 32'd0);
        check("pin_mid_rst_err",   32'(bus.err_out),  32'd0);
        check("pin_mid_rst_ready", 32'(bus.in_ready), 32'd0);
        rst = 1'b0;
        #1;
        check("pin_post_rst_ready", 32'(bus.in_ready), 32'd1);
        send_cell(0, 32'hAB00_0000);
        read_cell(0, 32'hAB00_0000);
        cyc();

        // Randomized traffic.
        for (int c = 0; c < 3000; c++) begin
            bus.in_valid = ($urandom_range(0, 3) != 0);
            bus.in_sop   = in_cell ? ($urandom_range(0, 19) == 0) : ($urandom_range(0, 5) != 0);
            bus.in_dest  = 2'($urandom_range(0, 3));
            bus.in_data  = $urandom;
            bus.rd_en    = ($urandom_range(0, 3) == 0);
            bus.rd_sel   = 2'($urandom_range(0, 3));
            rst          = ($urandom_range(0, 499) == 0);
            cyc();
        end
        rst = 1'b0;
        bus.in_valid = 1'b0;
        bus.rd_en = 1'b0;
        cyc(); cyc();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/voq_wr_ctrl.md
Name: voq_wr_ctrl

Overview:
- Input-side VOQ bank for one switch input port; the write end of the VOQ path whose read end is the switch mux controller.
- Accepts fixed-length cells from the port, steers each into the virtual output queue for its destination, and raises `full_out[d]` while VOQ d holds a complete cell.
- Streams a stored cell out when the controller issues `rd_en` + `rd_sel`.

Parameters:
- PORT_NUB, `PORT_NUB_TOTAL (4): number of destinations / VOQs.
- WIDTH_SEL, $clog2(PORT_NUB): destination select width.
- DATA_WIDTH, 32: cell word width.
- CELL_LEN, 4: words per cell, must be ≥2.
- VOQ_DEPTH, 2: cells stored per VOQ.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-high.
- in_valid  in  1  input word valid.
- in_ready  out  1  input word accepted when `in_valid & in_ready`.
- in_sop  in  1  first word of a cell.
- in_dest  in  WIDTH_SEL  destination; sampled only on the sop word.
- in_data  in  DATA_WIDTH  cell word.
- full_out  out  PORT_NUB  bit d high while VOQ d count > 0.
- rd_en  in  1  read request pulse, from controller `rd_out`.
- rd_sel  in  WIDTH_SEL  VOQ to read.
- rd_valid  out  1  rd_data valid.
- rd_data  out  DATA_WIDTH  cell word out.
- rd_busy  out  1  cell read in progress.
- err_out  out  1  one-cycle pulse on a protocol error.

Behaviour:
- Reset:
  - All outputs 0. `in_ready` is 0 during reset and 1 in the first cycle after it.
  - All counts, write/read pointers and word counters are 0; FSM goes to IDLE. Storage contents are don't-care.
  - Reset mid-cell discards the partial cell; reset mid-read aborts the read with no further `rd_valid`.
- Storage: PORT_NUB x VOQ_DEPTH x CELL_LEN words. Per VOQ: `wr_ptr`, `rd_ptr` (cell slot, wrap at VOQ_DEPTH-1 -> 0) and `cnt` (0..VOQ_DEPTH, committed cells).
- Write FSM:
  - IDLE:
    - `in_ready = (cnt[in_dest] < VOQ_DEPTH)`.
    - A word accepted with `in_sop=1` latches dest, writes word 0 and goes to RECV with `widx=1`.
    - A word with `in_valid & !in_sop` is consumed (`in_ready=1`), dropped, and pulses `err_out`.
  - RECV:
    - `in_ready = 1` unless `in_sop=1`.
    - An accepted word writes slot `[dest][wr_ptr][widx]` and increments `widx`.
    - On the word with `widx == CELL_LEN-1`: commit, i.e. `cnt[dest]++` and `wr_ptr[dest]` advances at that edge; return to IDLE.
    - `full_out[dest]` is high the cycle after the last word is accepted.
  - RECV with `in_valid & in_sop`: abort. `in_ready = 0`, `err_out` pulses, the partial cell is discarded (no pointer/count change), FSM goes to IDLE. The sop word is re-presented and handled by IDLE next cycle.
- Read:
  - `rd_en` is accepted when `rd_busy=0` and `cnt[rd_sel] > 0`. Otherwise it is ignored: no `rd_valid`, and `err_out` pulses if `cnt = 0`.
  - Acceptance at edge t latches sel and sets `rd_busy`. Words 0..CELL_LEN-1 from slot `rd_ptr[sel]` appear registered with `rd_valid=1` in cycles t+1 .. t+CELL_LEN, back-to-back.
  - On the edge emitting the last word: `cnt[sel]--`, `rd_ptr[sel]` advances, `rd_busy` clears. The slot stays reserved until the read finishes.
- Simultaneous commit and read-finish on the same VOQ: `cnt` is unchanged and `full_out` stays high.
- Write and read of different slots in the same VOQ proceed concurrently.
- `cnt` never exceeds VOQ_DEPTH and never underflows.

Test Plan:
- Reset, then cell to dest 2 with words A0..A3 on 4 consecutive cycles -> `full_out = 4'b0100` from the cycle after A3. `rd_en` with `rd_sel=2` -> `rd_data` A0..A3 with `rd_valid`, then `full_out = 0`.
- Three cells to dest 1 with VOQ_DEPTH=2 -> the third sop is held with `in_ready=0`. Start a read of dest 1 -> after the read's last word, `in_ready=1` and the third cell is accepted; FIFO order is preserved.
- `in_sop` reasserted at word 2 of a cell to dest 0 -> `err_out` pulses once, `cnt[0]` stays 0, and the following full cell to dest 3 is stored correctly.
- `rd_en` to an empty VOQ 3 -> `err_out` pulse, no `rd_valid`. `rd_en` while `rd_busy` -> ignored with no pulse.
- Dest 1 holds 1 cell. Read of dest 1 in progress while a new dest-1 cell's last word commits on the same edge as the read's last word -> `cnt[1]` stays 1 and `full_out[1]` stays high.
- `rst` asserted mid-cell and mid-read -> next cycle all outputs are 0 and `full_out = 0`. A subsequent cell to dest 0 stores and reads back correctly.
